// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, exception codes, FSM states and
// decode helpers for the memory access unit.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LD,
    OP_SB, OP_SH, OP_SW, OP_SD,
    OP_LL, OP_SC
  } mem_op_e;

  typedef enum logic [1:0] {
    EXC_LOAD_MIS  = 2'd0,
    EXC_STORE_MIS = 2'd1,
    EXC_BUS       = 2'd2
  } exc_code_e;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } mau_state_e;

  typedef enum logic [1:0] {
    SZ_B, SZ_H, SZ_W, SZ_D
  } mem_size_e;

  typedef struct packed {
    logic      mem;
    logic      load;
    logic      store;
    logic      uns;
    logic      ll;
    logic      sc;
    mem_size_e size;
  } mem_dec_t;

  function automatic mem_dec_t mem_decode(
    input logic [3:0] op,
    input logic       dw64
  );
    mem_dec_t d;
    d = '0;
    case (op)
      OP_LB:  begin d.mem = 1'b1; d.load = 1'b1; end
      OP_LBU: begin
        d.mem = 1'b1; d.load = 1'b1; d.uns = 1'b1;
      end
      OP_LH: begin
        d.mem = 1'b1; d.load = 1'b1; d.size = SZ_H;
      end
      OP_LHU: begin
        d.mem = 1'b1; d.load = 1'b1;
        d.uns = 1'b1; d.size = SZ_H;
      end
      OP_LW: begin
        d.mem = 1'b1; d.load = 1'b1; d.size = SZ_W;
      end
      OP_LD: if (dw64) begin
        d.mem = 1'b1; d.load = 1'b1; d.size = SZ_D;
      end
      OP_SB: begin d.mem = 1'b1; d.store = 1'b1; end
      OP_SH: begin
        d.mem = 1'b1; d.store = 1'b1; d.size = SZ_H;
      end
      OP_SW: begin
        d.mem = 1'b1; d.store = 1'b1; d.size = SZ_W;
      end
      OP_SD: if (dw64) begin
        d.mem = 1'b1; d.store = 1'b1; d.size = SZ_D;
      end
      OP_LL: begin
        d.mem = 1'b1; d.load = 1'b1;
        d.ll = 1'b1; d.size = SZ_W;
      end
      OP_SC: begin
        d.mem = 1'b1; d.store = 1'b1;
        d.sc = 1'b1; d.size = SZ_W;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic mem_misaligned(
    input mem_size_e  s,
    input logic [2:0] a
  );
    case (s)
      SZ_H:    return a[0];
      SZ_W:    return |a[1:0];
      SZ_D:    return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Big-endian byte-lane select, store replication and
// load extraction with sign/zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB)
) (
  input  mem_size_e         size,
  input  logic              uns,
  input  logic [OW-1:0]     off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     sel,
  output logic [DATA_W-1:0] wlanes,
  output logic [DATA_W-1:0] rdata_ext
);

  int n;
  int base;
  logic [DATA_W-1:0] shifted;
  logic msb;

  // base is the lowest lane touched: the access's last byte
  always_comb begin
    n = 1 << int'(size);
    base = NB - int'(off) - n;
    sel = '0;
    wlanes = '0;
    shifted = '0;
    msb = 1'b0;
    rdata_ext = '0;
    for (int k = 0; k < NB; k++) begin
      sel[k] = (k >= base) && (k < base + n);
      for (int j = 0; j < NB; j++) begin
        if (j == k % n)
          wlanes[8*k +: 8] = wdata[8*j +: 8];
        if (k - base == j)
          shifted[8*j +: 8] = rdata[8*k +: 8];
      end
    end
    for (int b = 0; b < DATA_W; b++)
      if (b == 8*n - 1) msb = shifted[b];
    for (int b = 0; b < DATA_W; b++)
      rdata_ext[b] = (b < 8*n) ? shifted[b] : (msb & ~uns);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: issues loads/stores on a
// valid/ready bus, handles LL/SC and bus timeouts.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [3:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_wd,
  input  logic                req_wreg,
  input  logic                flush,
  output logic                bus_req_valid,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_req_ready,
  input  logic                bus_rsp_valid,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_err,
  output logic                stall_req,
  output logic                wb_valid,
  output logic [4:0]          wb_wd,
  output logic                wb_wreg,
  output logic [DATA_W-1:0]   wb_wdata,
  output logic                exc_valid,
  output logic [1:0]          exc_code,
  output logic                llbit_o
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  mau_state_e state;
  mem_dec_t dec, dec_q;
  logic [OW-1:0] off_q;
  logic [4:0] wd_q;
  logic wreg_q;
  logic [CW-1:0] cnt;
  logic flushed, fl, llbit;
  logic misal, start, done_go;
  logic [NB-1:0] sel;
  logic [DATA_W-1:0] wlanes, ld_data;
  mem_size_e a_size;
  logic a_uns;
  logic [OW-1:0] a_off;

  assign dec = mem_decode(req_op, DATA_W == 64);
  assign misal = dec.mem &&
    mem_misaligned(dec.size, req_addr[2:0]);
  assign start = req_valid && !flush && dec.mem &&
    !misal && !(dec.sc && !llbit);
  assign stall_req = (state == S_ISSUE) ||
    (state == S_WAIT) ||
    (state == S_IDLE && start && !rst);
  assign llbit_o = llbit;
  assign fl = flushed || flush;

  assign done_go = !fl && !bus_err && bus_rsp_valid &&
    ((state == S_ISSUE && bus_req_ready) ||
     (state == S_WAIT));

  // Lane logic sees the request in IDLE, the held op after
  assign a_size = (state == S_IDLE) ? dec.size : dec_q.size;
  assign a_uns = (state == S_IDLE) ? dec.uns : dec_q.uns;
  assign a_off = (state == S_IDLE) ?
    req_addr[OW-1:0] : off_q;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size      (a_size),
    .uns       (a_uns),
    .off       (a_off),
    .wdata     (req_wdata),
    .rdata     (bus_rdata),
    .sel       (sel),
    .wlanes    (wlanes),
    .rdata_ext (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      dec_q <= '0;
      off_q <= '0;
      wd_q <= '0;
      wreg_q <= 1'b0;
      cnt <= '0;
      flushed <= 1'b0;
      llbit <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_we <= 1'b0;
      bus_sel <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
      wb_valid <= 1'b0;
      wb_wd <= '0;
      wb_wreg <= 1'b0;
      wb_wdata <= '0;
      exc_valid <= 1'b0;
      exc_code <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_wreg <= 1'b0;
      exc_valid <= 1'b0;
      unique case (state)
        S_IDLE: if (req_valid && !flush) begin
          if (!dec.mem) begin
            wb_valid <= 1'b1;
            wb_wd <= req_wd;
            wb_wreg <= req_wreg;
            wb_wdata <= req_wdata;
          end else if (misal) begin
            exc_valid <= 1'b1;
            exc_code <= dec.load ?
              EXC_LOAD_MIS : EXC_STORE_MIS;
          end else if (dec.sc && !llbit) begin
            wb_valid <= 1'b1;
            wb_wd <= req_wd;
            wb_wreg <= req_wreg;
            wb_wdata <= '0;
          end else begin
            state <= S_ISSUE;
            bus_req_valid <= 1'b1;
            bus_we <= dec.store;
            bus_sel <= sel;
            bus_addr <= {req_addr[ADDR_W-1:OW], OW'(0)};
            bus_wdata <= dec.store ? wlanes : '0;
            dec_q <= dec;
            off_q <= req_addr[OW-1:0];
            wd_q <= req_wd;
            wreg_q <= req_wreg;
            flushed <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (flush) flushed <= 1'b1;
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            bus_we <= 1'b0;
            bus_sel <= '0;
            bus_addr <= '0;
            bus_wdata <= '0;
            if (fl) state <= S_IDLE;
            else if (bus_err) begin
              state <= S_IDLE;
              exc_valid <= 1'b1;
              exc_code <= EXC_BUS;
            end else if (bus_rsp_valid) state <= S_DONE;
            else begin
              state <= S_WAIT;
              cnt <= CW'(1);
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (flush) flushed <= 1'b1;
          if (bus_err || (cnt == TO && !bus_rsp_valid)) begin
            state <= S_IDLE;
            cnt <= '0;
            if (!fl) begin
              exc_valid <= 1'b1;
              exc_code <= EXC_BUS;
            end
          end else if (bus_rsp_valid) begin
            state <= fl ? S_IDLE : S_DONE;
            cnt <= '0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (done_go) begin
        wb_valid <= 1'b1;
        wb_wd <= wd_q;
        wb_wreg <= wreg_q;
        wb_wdata <= dec_q.load ? ld_data :
          (dec_q.sc ? DATA_W'(1) : '0);
        if (dec_q.ll) llbit <= 1'b1;
        if (dec_q.sc) llbit <= 1'b0;
      end
      if (flush) llbit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit
// instance with TIMEOUT=8 and a 64-bit instance.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  logic a_req_valid, a_req_wreg, a_flush;
  logic [3:0] a_req_op;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [4:0] a_req_wd;
  logic a_bus_req_valid, a_bus_we;
  logic [3:0] a_bus_sel;
  logic [31:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic a_bus_req_ready, a_bus_rsp_valid, a_bus_err;
  logic a_stall, a_wb_valid, a_wb_wreg;
  logic [4:0] a_wb_wd;
  logic [31:0] a_wb_wdata;
  logic a_exc_valid, a_llbit;
  logic [1:0] a_exc_code;

  logic b_req_valid, b_req_wreg, b_flush;
  logic [3:0] b_req_op;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic [4:0] b_req_wd;
  logic b_bus_req_valid, b_bus_we;
  logic [7:0] b_bus_sel;
  logic [31:0] b_bus_addr;
  logic [63:0] b_bus_wdata, b_bus_rdata;
  logic b_bus_req_ready, b_bus_rsp_valid, b_bus_err;
  logic b_stall, b_wb_valid, b_wb_wreg;
  logic [4:0] b_wb_wd;
  logic [63:0] b_wb_wdata;
  logic b_exc_valid, b_llbit;
  logic [1:0] b_exc_code;

  mem_access_unit #(
    .DATA_W(32), .ADDR_W(32), .TIMEOUT(8)
  ) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .req_wd(a_req_wd), .req_wreg(a_req_wreg),
    .flush(a_flush),
    .bus_req_valid(a_bus_req_valid), .bus_we(a_bus_we),
    .bus_sel(a_bus_sel), .bus_addr(a_bus_addr),
    .bus_wdata(a_bus_wdata),
    .bus_req_ready(a_bus_req_ready),
    .bus_rsp_valid(a_bus_rsp_valid),
    .bus_rdata(a_bus_rdata), .bus_err(a_bus_err),
    .stall_req(a_stall),
    .wb_valid(a_wb_valid), .wb_wd(a_wb_wd),
    .wb_wreg(a_wb_wreg), .wb_wdata(a_wb_wdata),
    .exc_valid(a_exc_valid), .exc_code(a_exc_code),
    .llbit_o(a_llbit)
  );

  mem_access_unit #(
    .DATA_W(64), .ADDR_W(32), .TIMEOUT(255)
  ) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_wd(b_req_wd), .req_wreg(b_req_wreg),
    .flush(b_flush),
    .bus_req_valid(b_bus_req_valid), .bus_we(b_bus_we),
    .bus_sel(b_bus_sel), .bus_addr(b_bus_addr),
    .bus_wdata(b_bus_wdata),
    .bus_req_ready(b_bus_req_ready),
    .bus_rsp_valid(b_bus_rsp_valid),
    .bus_rdata(b_bus_rdata), .bus_err(b_bus_err),
    .stall_req(b_stall),
    .wb_valid(b_wb_valid), .wb_wd(b_wb_wd),
    .wb_wreg(b_wb_wreg), .wb_wdata(b_wb_wdata),
    .exc_valid(b_exc_valid), .exc_code(b_exc_code),
    .llbit_o(b_llbit)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
        tag, obs, exp);
    end
  endtask

  task automatic req_a(
    input logic [3:0]  op,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [4:0]  wd
  );
    a_req_op = op;
    a_req_addr = addr;
    a_req_wdata = wdata;
    a_req_wd = wd;
    a_req_wreg = 1'b1;
    a_req_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_op = 0; a_req_addr = 0;
    a_req_wdata = 0; a_req_wd = 0; a_req_wreg = 0;
    a_flush = 0; a_bus_req_ready = 0;
    a_bus_rsp_valid = 0; a_bus_rdata = 0; a_bus_err = 0;
    b_req_valid = 0; b_req_op = 0; b_req_addr = 0;
    b_req_wdata = 0; b_req_wd = 0; b_req_wreg = 0;
    b_flush = 0; b_bus_req_ready = 0;
    b_bus_rsp_valid = 0; b_bus_rdata = 0; b_bus_err = 0;
    step();
    step();
    chk("rst_bus_valid", a_bus_req_valid, 0);
    chk("rst_bus_sel", a_bus_sel, 0);
    chk("rst_wb_valid", a_wb_valid, 0);
    chk("rst_exc_valid", a_exc_valid, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_llbit", a_llbit, 0);
    chk("rst_b_bus_addr", b_bus_addr, 0);
    rst = 1'b0;

    // LB 0x1003, rdata 0xF0 sign-extends
    req_a(OP_LB, 32'h1003, 0, 5'd5);
    #1 chk("lb_stall_comb", a_stall, 1);
    step();
    chk("lb_bus_valid", a_bus_req_valid, 1);
    chk("lb_bus_sel", a_bus_sel, 4'b0001);
    chk("lb_bus_addr", a_bus_addr, 32'h1000);
    chk("lb_bus_we", a_bus_we, 0);
    a_req_valid = 0;
    a_bus_req_ready = 1;
    step();
    a_bus_req_ready = 0;
    chk("lb_wait_stall", a_stall, 1);
    a_bus_rsp_valid = 1;
    a_bus_rdata = 32'h0000_00F0;
    step();
    a_bus_rsp_valid = 0;
    chk("lb_wb_valid", a_wb_valid, 1);
    chk("lb_wb_wdata", a_wb_wdata, 32'hFFFF_FFF0);
    chk("lb_wb_wd", a_wb_wd, 5);
    chk("lb_done_stall", a_stall, 0);
    step();
    chk("lb_wb_drop", a_wb_valid, 0);

    // SH 0xABCD at 0x1002, ready after 3 cycles
    req_a(OP_SH, 32'h1002, 32'h0000_ABCD, 5'd2);
    step();
    a_req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_bus_valid", a_bus_req_valid, 1);
      chk("sh_bus_sel", a_bus_sel, 4'b0011);
      chk("sh_bus_wdata", a_bus_wdata, 32'hABCD_ABCD);
      chk("sh_bus_we", a_bus_we, 1);
      chk("sh_stall", a_stall, 1);
      if (i == 2) a_bus_req_ready = 1;
      step();
    end
    a_bus_req_ready = 0;
    chk("sh_bus_drop", a_bus_req_valid, 0);
    chk("sh_wait_stall", a_stall, 1);
    a_bus_rsp_valid = 1;
    step();
    a_bus_rsp_valid = 0;
    chk("sh_wb_valid", a_wb_valid, 1);
    chk("sh_wb_wdata", a_wb_wdata, 0);
    chk("sh_done_stall", a_stall, 0);
    step();

    // LW misaligned
    req_a(OP_LW, 32'h1001, 0, 5'd1);
    #1 chk("lw_mis_stall", a_stall, 0);
    step();
    a_req_valid = 0;
    chk("lw_mis_exc", a_exc_valid, 1);
    chk("lw_mis_code", a_exc_code, 0);
    chk("lw_mis_bus", a_bus_req_valid, 0);
    chk("lw_mis_wreg", a_wb_wreg, 0);
    step();
    chk("lw_mis_exc_drop", a_exc_valid, 0);

    // NOP and LD on a 32-bit bus pass through
    req_a(OP_NOP, 32'h0, 32'h55AA, 5'd7);
    step();
    chk("nop_wb_valid", a_wb_valid, 1);
    chk("nop_wb_wdata", a_wb_wdata, 32'h55AA);
    chk("nop_wb_wd", a_wb_wd, 7);
    req_a(OP_LD, 32'h10, 32'h1234, 5'd9);
    #1 chk("ld32_stall", a_stall, 0);
    step();
    a_req_valid = 0;
    chk("ld32_wb_wdata", a_wb_wdata, 32'h1234);
    chk("ld32_bus", a_bus_req_valid, 0);
    step();

    // LL then SC succeeds, second SC fails
    req_a(OP_LL, 32'h2000, 0, 5'd3);
    step();
    a_req_valid = 0;
    a_bus_req_ready = 1;
    a_bus_rsp_valid = 1;
    a_bus_rdata = 32'h1234_5678;
    step();
    a_bus_req_ready = 0;
    a_bus_rsp_valid = 0;
    chk("ll_wb_wdata", a_wb_wdata, 32'h1234_5678);
    chk("ll_llbit", a_llbit, 1);
    step();
    req_a(OP_SC, 32'h2000, 32'hCAFE_F00D, 5'd4);
    #1 chk("sc_stall", a_stall, 1);
    step();
    a_req_valid = 0;
    chk("sc_bus_we", a_bus_we, 1);
    chk("sc_bus_wdata", a_bus_wdata, 32'hCAFE_F00D);
    chk("sc_bus_sel", a_bus_sel, 4'b1111);
    a_bus_req_ready = 1;
    step();
    a_bus_req_ready = 0;
    a_bus_rsp_valid = 1;
    step();
    a_bus_rsp_valid = 0;
    chk("sc_wb_wdata", a_wb_wdata, 1);
    chk("sc_llbit_clr", a_llbit, 0);
    step();
    req_a(OP_SC, 32'h2000, 32'hCAFE_F00D, 5'd4);
    #1 chk("sc2_stall", a_stall, 0);
    step();
    a_req_valid = 0;
    chk("sc2_wb_valid", a_wb_valid, 1);
    chk("sc2_wb_wdata", a_wb_wdata, 0);
    chk("sc2_bus", a_bus_req_valid, 0);
    step();

    // LL, flush, SC fails
    req_a(OP_LL, 32'h2000, 0, 5'd3);
    step();
    a_req_valid = 0;
    a_bus_req_ready = 1;
    a_bus_rsp_valid = 1;
    step();
    a_bus_req_ready = 0;
    a_bus_rsp_valid = 0;
    chk("ll2_llbit", a_llbit, 1);
    step();
    a_flush = 1;
    step();
    a_flush = 0;
    chk("flush_llbit", a_llbit, 0);
    req_a(OP_SC, 32'h2000, 32'h1, 5'd4);
    step();
    a_req_valid = 0;
    chk("scf_wb_wdata", a_wb_wdata, 0);
    chk("scf_bus", a_bus_req_valid, 0);
    step();

    // flush in WAIT drains the response silently
    req_a(OP_LW, 32'h3000, 0, 5'd6);
    step();
    a_req_valid = 0;
    a_bus_req_ready = 1;
    step();
    a_bus_req_ready = 0;
    a_flush = 1;
    step();
    a_flush = 0;
    a_bus_rsp_valid = 1;
    step();
    a_bus_rsp_valid = 0;
    chk("fw_wb_valid", a_wb_valid, 0);
    chk("fw_stall", a_stall, 0);

    // no response: bus error after 8 WAIT cycles
    req_a(OP_LW, 32'h3000, 0, 5'd6);
    step();
    a_req_valid = 0;
    a_bus_req_ready = 1;
    step();
    a_bus_req_ready = 0;
    for (int i = 0; i < 8; i++) begin
      chk("to_exc_early", a_exc_valid, 0);
      chk("to_stall", a_stall, 1);
      step();
    end
    chk("to_exc_valid", a_exc_valid, 1);
    chk("to_exc_code", a_exc_code, 2);
    chk("to_idle_stall", a_stall, 0);
    step();
    chk("to_exc_drop", a_exc_valid, 0);

    // reset mid-transaction, then stale response
    req_a(OP_LW, 32'h3000, 0, 5'd6);
    step();
    a_req_valid = 0;
    a_bus_req_ready = 1;
    step();
    a_bus_req_ready = 0;
    rst = 1;
    step();
    rst = 0;
    chk("mrst_stall", a_stall, 0);
    a_bus_rsp_valid = 1;
    step();
    a_bus_rsp_valid = 0;
    chk("stale_wb_valid", a_wb_valid, 0);
    chk("stale_exc", a_exc_valid, 0);

    // 64-bit: LD at 0x8
    b_req_op = OP_LD; b_req_addr = 32'h8;
    b_req_wd = 5'd1; b_req_wreg = 1; b_req_valid = 1;
    step();
    b_req_valid = 0;
    chk("ld64_bus_sel", b_bus_sel, 8'hFF);
    chk("ld64_bus_addr", b_bus_addr, 32'h8);
    b_bus_req_ready = 1;
    b_bus_rsp_valid = 1;
    b_bus_rdata = 64'h1122_3344_5566_7788;
    step();
    chk("ld64_wb_wdata", b_wb_wdata, 64'h1122_3344_5566_7788);
    b_bus_req_ready = 0;
    b_bus_rsp_valid = 0;
    step();

    // 64-bit: LW at 0xC sign-extends the low word
    b_req_op = OP_LW; b_req_addr = 32'hC;
    b_req_valid = 1;
    step();
    b_req_valid = 0;
    chk("lw64_bus_sel", b_bus_sel, 8'h0F);
    chk("lw64_bus_addr", b_bus_addr, 32'h8);
    b_bus_req_ready = 1;
    b_bus_rsp_valid = 1;
    b_bus_rdata = 64'h0000_0000_8000_0001;
    step();
    chk("lw64_wb_wdata", b_wb_wdata, 64'hFFFF_FFFF_8000_0001);
    b_bus_req_ready = 0;
    b_bus_rsp_valid = 0;
    step();

    // 64-bit: LBU at 0x9 zero-extends lane 6
    b_req_op = OP_LBU; b_req_addr = 32'h9;
    b_req_valid = 1;
    step();
    b_req_valid = 0;
    chk("lbu64_bus_sel", b_bus_sel, 8'h40);
    b_bus_req_ready = 1;
    b_bus_rsp_valid = 1;
    b_bus_rdata = 64'h11F2_3344_5566_7788;
    step();
    chk("lbu64_wb_wdata", b_wb_wdata, 64'hF2);
    b_bus_req_ready = 0;
    b_bus_rsp_valid = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
